// File: rtl/dog_animator.sv
// dog_animator: per-frame motion and animation controller for the hunting-dog sprite
module dog_animator #(
    parameter logic [9:0] WALK_START_X = 10'd0,
    parameter logic [9:0] WALK_Y       = 10'd360,
    parameter logic [9:0] SNIFF_X      = 10'd120,
    parameter logic [9:0] JUMP_X       = 10'd240,
    parameter logic [9:0] WALK_STEP    = 10'd2,
    parameter logic [9:0] JUMP_STEP    = 10'd4,
    parameter logic [9:0] HIDE_Y       = 10'd400,
    parameter logic [9:0] POP_Y        = 10'd330,
    parameter logic [9:0] POP_STEP     = 10'd2,
    parameter logic [9:0] MAX_X        = 10'd584,
    parameter logic [6:0] JUMP_TICKS   = 7'd12,
    parameter logic [6:0] SNIFF_TICKS  = 7'd60,
    parameter logic [6:0] SHOW_TICKS   = 7'd60,
    parameter logic [3:0] FRAME_DIV    = 4'd8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       duck_hit,
    input  logic       duck_miss,
    input  logic [9:0] duck_x,
    output logic [9:0] Dog_X_pos_out,
    output logic [9:0] Dog_Y_pos_out,
    output logic [4:0] Frame,
    output logic       dog_visible,
    output logic       busy,
    output logic       round_ready
);
    typedef enum logic [3:0] {IDLE, WALK1, SNIFF, WALK2, JUMP_UP, JUMP_DOWN, HIDDEN, POP_UP, SHOW, POP_DOWN} state_t;
    state_t state, state_n;
    logic frame_clk_q, tick, adv, laugh, laugh_n, vis_n;
    logic [6:0] cnt, cnt_n;
    logic [3:0] div, div_n;
    logic [4:0] frame_n;
    logic [9:0] x_n, y_n, x_adv, duck_xc, y_jump_up, y_jump_dn, y_pop_up, y_pop_dn;
    logic [10:0] x_sum, y_jsum, y_psum;
    // all steps are done 11 bits wide and clamped to their bound so nothing wraps
    assign x_sum     = {1'b0, Dog_X_pos_out} + {1'b0, WALK_STEP};
    assign x_adv     = x_sum > {1'b0, MAX_X} ? MAX_X : x_sum[9:0];
    assign duck_xc   = duck_x > MAX_X ? MAX_X : duck_x;
    assign y_jsum    = {1'b0, Dog_Y_pos_out} + {1'b0, JUMP_STEP};
    assign y_psum    = {1'b0, Dog_Y_pos_out} + {1'b0, POP_STEP};
    assign y_jump_dn = y_jsum >= {1'b0, HIDE_Y} ? HIDE_Y : y_jsum[9:0];
    assign y_pop_dn  = y_psum >= {1'b0, HIDE_Y} ? HIDE_Y : y_psum[9:0];
    assign y_jump_up = Dog_Y_pos_out >= JUMP_STEP ? Dog_Y_pos_out - JUMP_STEP : '0;
    assign y_pop_up  = Dog_Y_pos_out < POP_Y + POP_STEP ? POP_Y : Dog_Y_pos_out - POP_STEP;
    assign adv       = tick && div == FRAME_DIV - 4'd1;
    assign busy      = state != IDLE && state != HIDDEN;
    always_ff @(posedge Clk)
        if (Reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      state_n = start ? WALK1 : IDLE;
            WALK1:     if (tick && x_adv >= SNIFF_X) state_n = SNIFF;
            SNIFF:     if (tick && cnt == SNIFF_TICKS - 7'd1) state_n = WALK2;
            WALK2:     if (tick && x_adv >= JUMP_X) state_n = JUMP_UP;
            JUMP_UP:   if (tick && cnt == JUMP_TICKS - 7'd1) state_n = JUMP_DOWN;
            JUMP_DOWN: if (tick && y_jump_dn == HIDE_Y) state_n = HIDDEN;
            HIDDEN:    state_n = (duck_hit || duck_miss) ? POP_UP : start ? WALK1 : HIDDEN;
            POP_UP:    if (tick && y_pop_up == POP_Y) state_n = SHOW;
            SHOW:      if (tick && cnt == SHOW_TICKS - 7'd1) state_n = POP_DOWN;
            POP_DOWN:  if (tick && y_pop_dn == HIDE_Y) state_n = HIDDEN;
            default:   state_n = IDLE;
        endcase
    end
    // per-tick motion first, then entry actions of the next state override it
    always_comb begin
        x_n     = Dog_X_pos_out;
        y_n     = Dog_Y_pos_out;
        frame_n = Frame;
        vis_n   = dog_visible;
        laugh_n = laugh;
        cnt_n   = tick ? cnt + 7'd1 : cnt;
        div_n   = adv ? '0 : tick ? div + 4'd1 : div;
        if (tick)
            case (state)
                WALK1, WALK2: begin
                    x_n = x_adv;
                    if (adv) frame_n = {3'd0, Frame[1:0] + 2'd1};
                end
                SNIFF:     if (adv) frame_n = Frame == 5'd4 ? 5'd5 : 5'd4;
                JUMP_UP: begin
                    x_n = x_adv;
                    y_n = y_jump_up;
                end
                JUMP_DOWN: y_n = y_jump_dn;
                POP_UP:    y_n = y_pop_up;
                SHOW:      if (adv && laugh) frame_n = Frame == 5'd9 ? 5'd10 : 5'd9;
                POP_DOWN:  y_n = y_pop_dn;
                default:   ;
            endcase
        if (state_n != state) begin
            cnt_n = '0;
            div_n = '0;
            case (state_n)
                WALK1: begin
                    x_n     = WALK_START_X;
                    y_n     = WALK_Y;
                    frame_n = 5'd0;
                    vis_n   = 1'b1;
                end
                SNIFF: begin
                    x_n     = SNIFF_X;
                    frame_n = 5'd4;
                end
                WALK2:     frame_n = 5'd0;
                JUMP_UP: begin
                    x_n     = JUMP_X;
                    frame_n = 5'd6;
                end
                JUMP_DOWN: frame_n = 5'd7;
                HIDDEN:    vis_n = 1'b0;
                POP_UP: begin
                    x_n     = duck_hit ? duck_xc : Dog_X_pos_out;
                    y_n     = HIDE_Y;
                    frame_n = duck_hit ? 5'd8 : 5'd9;
                    vis_n   = 1'b1;
                    laugh_n = !duck_hit;
                end
                default:   ;
            endcase
        end
    end
    always_ff @(posedge Clk)
        if (Reset) begin
            frame_clk_q   <= 1'b0;
            tick          <= 1'b0;
            Dog_X_pos_out <= WALK_START_X;
            Dog_Y_pos_out <= WALK_Y;
            Frame         <= '0;
            dog_visible   <= 1'b0;
            round_ready   <= 1'b0;
            laugh         <= 1'b0;
            cnt           <= '0;
            div           <= '0;
        end else begin
            frame_clk_q   <= frame_clk;
            tick          <= frame_clk & ~frame_clk_q;
            Dog_X_pos_out <= x_n;
            Dog_Y_pos_out <= y_n;
            Frame         <= frame_n;
            dog_visible   <= vis_n;
            round_ready   <= state_n == HIDDEN && state != HIDDEN;
            laugh         <= laugh_n;
            cnt           <= cnt_n;
            div           <= div_n;
        end
endmodule

// File: tb/tb_dog_animator.sv
// tb_dog_animator: scoreboard bench for the dog sprite animator
module tb_dog_animator;
    logic Clk = 0, Reset = 1, frame_clk = 0, start = 0, duck_hit = 0, duck_miss = 0;
    logic [9:0] duck_x = '0;
    logic [9:0] Dog_X_pos_out, Dog_Y_pos_out;
    logic [4:0] Frame;
    logic dog_visible, busy, round_ready;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] f;
        logic       v;
        logic       b;
    } snap_t;
    snap_t q[$];
    int checks = 0, failures = 0;
    always #5 Clk = ~Clk;
    dog_animator dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .duck_hit(duck_hit), .duck_miss(duck_miss), .duck_x(duck_x),
        .Dog_X_pos_out(Dog_X_pos_out), .Dog_Y_pos_out(Dog_Y_pos_out), .Frame(Frame),
        .dog_visible(dog_visible), .busy(busy), .round_ready(round_ready)
    );
    function automatic snap_t mk(input int x, input int y, input int f, input logic v, input logic b);
        snap_t s;
        s.x = 10'(x);
        s.y = 10'(y);
        s.f = 5'(f);
        s.v = v;
        s.b = b;
        return s;
    endfunction
    function automatic snap_t cur();
        snap_t s;
        s.x = Dog_X_pos_out;
        s.y = Dog_Y_pos_out;
        s.f = Frame;
        s.v = dog_visible;
        s.b = busy;
        return s;
    endfunction
    function automatic string fmt(input snap_t s);
        return $sformatf("x=%0d y=%0d frame=%0d vis=%0b busy=%0b", s.x, s.y, s.f, s.v, s.b);
    endfunction
    task automatic do_tick();
        @(negedge Clk) frame_clk = 1;
        @(negedge Clk) frame_clk = 0;
        @(negedge Clk);
    endtask
    task automatic pulse(input logic s, input logic h, input logic m);
        @(negedge Clk) begin start = s; duck_hit = h; duck_miss = m; end
        @(negedge Clk) begin start = 0; duck_hit = 0; duck_miss = 0; end
    endtask
    task automatic test_reset();
        snap_t e;
        repeat (3) @(negedge Clk);
        Reset = 0;
        q.push_back(mk(0, 360, 0, 0, 0));
        @(negedge Clk);
        e = q.pop_front(); checks++;
        if (cur() !== e || round_ready !== 1'b0) begin failures++; $display("FAIL reset got %s rr=%b want %s rr=0", fmt(cur()), round_ready, fmt(e)); end
        q.push_back(mk(0, 360, 0, 0, 0));
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL idle_events got %s want %s", fmt(cur()), fmt(e)); end
        for (int i = 1; i <= 5; i++) begin
            q.push_back(mk(0, 360, 0, 0, 0));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL idle_tick%0d got %s want %s", i, fmt(cur()), fmt(e)); end
        end
    endtask
    task automatic test_intro();
        snap_t e;
        q.push_back(mk(0, 360, 0, 1, 1));
        pulse(1, 0, 0);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL start got %s want %s", fmt(cur()), fmt(e)); end
        for (int i = 1; i <= 60; i++) begin
            q.push_back(mk(2 * i, 360, i == 60 ? 4 : (i / 8) % 4, 1, 1));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL walk1 tick%0d got %s want %s", i, fmt(cur()), fmt(e)); end
        end
        for (int j = 1; j <= 60; j++) begin
            q.push_back(mk(120, 360, j == 60 ? 0 : 4 + (j / 8) % 2, 1, 1));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL sniff tick%0d got %s want %s", j, fmt(cur()), fmt(e)); end
        end
        for (int k = 1; k <= 60; k++) begin
            q.push_back(mk(120 + 2 * k, 360, k == 60 ? 6 : (k / 8) % 4, 1, 1));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL walk2 tick%0d got %s want %s", k, fmt(cur()), fmt(e)); end
        end
        for (int m = 1; m <= 12; m++) begin
            q.push_back(mk(240 + 2 * m, 360 - 4 * m, m == 12 ? 7 : 6, 1, 1));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL jump_up tick%0d got %s want %s", m, fmt(cur()), fmt(e)); end
        end
        for (int n = 1; n <= 22; n++) begin
            q.push_back(mk(264, 312 + 4 * n, 7, n != 22, n != 22));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e || round_ready !== (n == 22)) begin failures++; $display("FAIL jump_down tick%0d got %s rr=%b want %s rr=%b", n, fmt(cur()), round_ready, fmt(e), n == 22); end
        end
        @(negedge Clk);
        checks++;
        if (round_ready !== 1'b0) begin failures++; $display("FAIL round_ready_width got %b want 0", round_ready); end
    endtask
    task automatic test_hit_clamp();
        snap_t e;
        duck_x = 10'd700;
        q.push_back(mk(584, 400, 8, 1, 1));
        pulse(0, 1, 0);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL hit_entry got %s want %s", fmt(cur()), fmt(e)); end
        for (int k = 1; k <= 35; k++) begin
            q.push_back(mk(584, 400 - 2 * k, 8, 1, 1));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL hit_up tick%0d got %s want %s", k, fmt(cur()), fmt(e)); end
        end
        for (int s = 1; s <= 60; s++) begin
            q.push_back(mk(584, 330, 8, 1, 1));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL hit_show tick%0d got %s want %s", s, fmt(cur()), fmt(e)); end
        end
        for (int d = 1; d <= 35; d++) begin
            q.push_back(mk(584, 330 + 2 * d, 8, d != 35, d != 35));
            do_tick();
            e = q.pop_front(); checks++;
            if (cur() !== e || round_ready !== (d == 35)) begin failures++; $display("FAIL hit_down tick%0d got %s rr=%b want %s", d, fmt(cur()), round_ready, fmt(e)); end
        end
    endtask
    task automatic test_priority();
        snap_t e;
        duck_x = 10'd100;
        q.push_back(mk(100, 400, 8, 1, 1));
        pulse(1, 1, 1);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL priority_entry got %s want %s", fmt(cur()), fmt(e)); end
        q.push_back(mk(100, 400, 8, 0, 0));
        repeat (130) do_tick();
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL priority_round got %s want %s", fmt(cur()), fmt(e)); end
    endtask
    task automatic test_miss();
        snap_t e;
        duck_x = 10'd500;
        q.push_back(mk(100, 400, 9, 1, 1));
        pulse(0, 0, 1);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL miss_entry got %s want %s", fmt(cur()), fmt(e)); end
        q.push_back(mk(100, 330, 9, 1, 1));
        repeat (35) do_tick();
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL miss_top got %s want %s", fmt(cur()), fmt(e)); end
        for (int s = 1; s <= 60; s++) begin
            q.push_back(mk(100, 330, 9 + (s / 8) % 2, 1, 1));
            do_tick();
            if (s == 20) pulse(1, 1, 0);
            e = q.pop_front(); checks++;
            if (cur() !== e) begin failures++; $display("FAIL miss_show tick%0d got %s want %s", s, fmt(cur()), fmt(e)); end
        end
        q.push_back(mk(100, 400, 10, 0, 0));
        repeat (35) do_tick();
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL miss_down got %s want %s", fmt(cur()), fmt(e)); end
    endtask
    task automatic test_reset_mid_jump();
        snap_t e;
        q.push_back(mk(0, 360, 0, 1, 1));
        pulse(1, 0, 0);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL rerun_start got %s want %s", fmt(cur()), fmt(e)); end
        q.push_back(mk(240, 360, 6, 1, 1));
        repeat (180) do_tick();
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL rerun_jump_entry got %s want %s", fmt(cur()), fmt(e)); end
        q.push_back(mk(246, 348, 6, 1, 1));
        repeat (3) do_tick();
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL rerun_jump3 got %s want %s", fmt(cur()), fmt(e)); end
        q.push_back(mk(0, 360, 0, 0, 0));
        @(negedge Clk) Reset = 1;
        @(negedge Clk);
        e = q.pop_front(); checks++;
        if (cur() !== e || round_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got %s rr=%b want %s", fmt(cur()), round_ready, fmt(e)); end
        Reset = 0;
    endtask
    task automatic test_level_hold();
        snap_t e;
        pulse(1, 0, 0);
        q.push_back(mk(2, 360, 0, 1, 1));
        @(negedge Clk) frame_clk = 1;
        repeat (10) @(negedge Clk);
        frame_clk = 0;
        @(negedge Clk);
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL level_hold got %s want %s", fmt(cur()), fmt(e)); end
        q.push_back(mk(4, 360, 0, 1, 1));
        do_tick();
        e = q.pop_front(); checks++;
        if (cur() !== e) begin failures++; $display("FAIL level_next got %s want %s", fmt(cur()), fmt(e)); end
    endtask
    initial begin
        test_reset();
        test_intro();
        test_hit_clamp();
        test_priority();
        test_miss();
        test_reset_mid_jump();
        test_level_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
